// File: rtl/inertial_delay_shifter.sv
// Multi-channel clocked inertial delay: per-channel rise/fall filtering of an
// optionally inverted input, with the filtered value shifted into a history register.
module inertial_delay_shifter #(
    parameter int unsigned CH     = 1,
    parameter int unsigned HIST_W = 32,
    parameter int unsigned CNT_W  = 4,
    parameter int unsigned INVERT = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [CH-1:0]        x,
    input  logic [CNT_W-1:0]     rise_dly,
    input  logic [CNT_W-1:0]     fall_dly,
    output logic [CH-1:0]        nn,
    output logic [CH*HIST_W-1:0] y,
    output logic [CH-1:0]        busy
);

    localparam logic INV = (INVERT != 0);

    logic [CH-1:0]     nn_q;
    logic [CH-1:0]     nn_next;
    logic [CH-1:0]     s;
    logic [CNT_W-1:0]  d        [CH];
    logic [CNT_W-1:0]  cnt_q    [CH];
    logic [CNT_W-1:0]  cnt_next [CH];
    logic [HIST_W-1:0] hist_q   [CH];

    // Delays are compared live, so lowering a delay mid-count can commit at once.
    always_comb begin
        nn_next = nn_q;
        s       = '0;
        for (int unsigned c = 0; c < CH; c++) begin
            s[c]        = x[c] ^ INV;
            d[c]        = s[c] ? rise_dly : fall_dly;
            cnt_next[c] = cnt_q[c];
            if (s[c] == nn_q[c]) begin
                cnt_next[c] = '0;
            end else if (cnt_q[c] >= d[c]) begin
                nn_next[c]  = s[c];
                cnt_next[c] = '0;
            end else begin
                cnt_next[c] = cnt_q[c] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            nn_q <= {CH{INV}};
            for (int unsigned c = 0; c < CH; c++) begin
                cnt_q[c]  <= '0;
                hist_q[c] <= {HIST_W{INV}};
            end
        end else if (en) begin
            nn_q <= nn_next;
            for (int unsigned c = 0; c < CH; c++) begin
                cnt_q[c]  <= cnt_next[c];
                hist_q[c] <= {hist_q[c][HIST_W-2:0], nn_next[c]};
            end
        end
    end

    assign nn = nn_q;

    for (genvar gc = 0; gc < CH; gc++) begin : g_out
        assign y[gc*HIST_W +: HIST_W] = hist_q[gc];
        assign busy[gc]               = (cnt_q[gc] != '0);
    end

endmodule

// File: tb/tb_inertial_delay_shifter.sv
// Scoreboard bench for inertial_delay_shifter (CH=2, HIST_W=8, CNT_W=4, INVERT=1):
// a run-length reference model queues expectations, a monitor compares each edge.
module tb_inertial_delay_shifter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [1:0] x;
    logic [3:0] rise_dly;
    logic [3:0] fall_dly;
    logic [1:0] nn;
    logic [15:0] y;
    logic [1:0] busy;

    inertial_delay_shifter #(
        .CH(2), .HIST_W(8), .CNT_W(4), .INVERT(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .x(x),
        .rise_dly(rise_dly), .fall_dly(fall_dly),
        .nn(nn), .y(y), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  nn;
        logic [15:0] y;
        logic [1:0]  busy;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad   = 0;

    // Reference model: filtered value, length of the current run of enabled
    // edges where the input disagrees with it, and a list of past filtered values.
    logic [1:0] m_nn;
    int         m_run [2];
    logic [1:0] m_past[$];

    task automatic step(input logic r, input logic e, input logic [1:0] xi,
                        input logic [3:0] rd, input logic [3:0] fd);
        exp_t ex;
        logic s;
        int   dl;
        @(negedge clk);
        rst_n = r; en = e; x = xi; rise_dly = rd; fall_dly = fd;
        if (!r) begin
            m_nn = 2'b11;
            m_run[0] = 0; m_run[1] = 0;
            m_past.delete();
            for (int i = 0; i < 8; i++) m_past.push_back(2'b11);
        end else if (e) begin
            for (int c = 0; c < 2; c++) begin
                s  = ~xi[c];
                dl = s ? int'(rd) : int'(fd);
                if (s == m_nn[c]) begin
                    m_run[c] = 0;
                end else begin
                    m_run[c]++;
                    if (m_run[c] > dl) begin
                        m_nn[c]  = s;
                        m_run[c] = 0;
                    end
                end
            end
            m_past.push_front(m_nn);
            if (m_past.size() > 8) void'(m_past.pop_back());
        end
        ex.nn = m_nn;
        for (int c = 0; c < 2; c++) begin
            ex.busy[c] = (m_run[c] != 0);
            for (int i = 0; i < 8; i++) ex.y[c*8+i] = m_past[i][c];
        end
        sb.push_back(ex);
        @(posedge clk);
    endtask

    initial begin : monitor
        exp_t ex;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                ex = sb.pop_front();
                total++;
                if (nn !== ex.nn) begin
                    bad++;
                    $display("FAIL nn t=%0t got=%b want=%b", $time, nn, ex.nn);
                end
                total++;
                if (y !== ex.y) begin
                    bad++;
                    $display("FAIL y t=%0t got=%h want=%h", $time, y, ex.y);
                end
                total++;
                if (busy !== ex.busy) begin
                    bad++;
                    $display("FAIL busy t=%0t got=%b want=%b", $time, busy, ex.busy);
                end
            end
        end
    end

    initial begin : stim
        logic [1:0] xr;
        logic [3:0] rr, fr;
        logic       er, rs;
        rst_n = 1'b1; en = 1'b0; x = 2'b00; rise_dly = '0; fall_dly = '0;
        m_nn = 2'b11; m_run[0] = 0; m_run[1] = 0;

        // reset with x=11, then release with x=00
        step(1'b0, 1'b1, 2'b11, 4'd1, 4'd1);
        step(1'b0, 1'b1, 2'b11, 4'd1, 4'd1);
        step(1'b1, 1'b1, 2'b00, 4'd1, 4'd1);

        // fall delay of 1 on channel 0
        repeat (3) step(1'b1, 1'b1, 2'b01, 4'd3, 4'd1);

        // inertial rejection: 3-edge pulse rejected, 4-edge pulse passes
        repeat (3) step(1'b1, 1'b1, 2'b00, 4'd3, 4'd1);
        step(1'b1, 1'b1, 2'b01, 4'd3, 4'd1);
        step(1'b1, 1'b1, 2'b01, 4'd3, 4'd1);
        repeat (4) step(1'b1, 1'b1, 2'b00, 4'd3, 4'd1);

        // zero delay: toggle channel 1 every edge
        for (int i = 0; i < 10; i++)
            step(1'b1, 1'b1, {i[0], 1'b1}, 4'd0, 4'd0);

        // freeze mid-count, then lower the delay
        step(1'b1, 1'b1, 2'b11, 4'd0, 4'd0);
        repeat (5) step(1'b1, 1'b1, 2'b10, 4'd10, 4'd10);
        repeat (5) step(1'b1, 1'b0, 2'b01, 4'd10, 4'd0);
        step(1'b1, 1'b1, 2'b10, 4'd2, 4'd10);
        step(1'b1, 1'b1, 2'b10, 4'd2, 4'd10);

        // reset with changes pending on both channels
        repeat (3) step(1'b1, 1'b1, m_nn, 4'd10, 4'd10);
        step(1'b0, 1'b1, m_nn, 4'd10, 4'd10);
        repeat (3) step(1'b1, 1'b1, 2'b00, 4'd10, 4'd10);

        // random traffic with held inputs, varying delays and enable
        xr = 2'b00; rr = 4'd2; fr = 4'd2;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) xr = 2'($urandom);
            if ($urandom_range(0, 15) == 0) rr = 4'($urandom_range(0, 6));
            if ($urandom_range(0, 15) == 0) fr = 4'($urandom_range(0, 6));
            er = ($urandom_range(0, 7) != 0);
            rs = ($urandom_range(0, 99) != 0);
            step(rs, er, xr, rr, fr);
        end

        repeat (2) @(posedge clk);
        #2;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/inertial_delay_shifter.md
# inertial_delay_shifter

Parametrised, clocked successor to the net-delay test blocks: each of CH channels optionally inverts its input, applies separately programmable rise and fall inertial delays counted in clock cycles, and shifts the filtered value into a per-channel HIST_W-bit history register. Pulses shorter than the programmed delay are rejected. It sits between asynchronous-style stimulus and synthesis-comparison logic, giving a synthesisable model of `#(rise,fall)` net delay.

## Interface
- CH, 1: number of independent channels
- HIST_W, 32: history register width per channel (≥2)
- CNT_W, 4: width of delay inputs and per-channel counter
- INVERT, 1: 1 = channel input is inverted before filtering (NOT gate), 0 = buffer

- clk  in  1  rising-edge clock
- rst_n  in  1  reset, synchronous, active-low
- en  in  1  cycle enable; 0 freezes all state
- x  in  CH  raw inputs
- rise_dly  in  CNT_W  cycles a 0→1 change of the filtered value must persist (shared by all channels)
- fall_dly  in  CNT_W  same for 1→0
- nn  out  CH  filtered (delayed) value per channel, registered
- y  out  CH*HIST_W  history; channel c at y[c*HIST_W +: HIST_W], bit 0 newest
- busy  out  CH  channel has a pending, not-yet-committed change (cnt ≠ 0)

## Operation
- Per channel: s = x[c] ^ INVERT; state nn[c], cnt[c] (CNT_W bits), hist[c].
- Reset (rst_n=0 at an edge, overrides en): nn = {CH{INVERT}}, cnt = 0, every hist = {HIST_W{INVERT}}, busy = 0.
- en=0: nn, cnt, y hold; inputs ignored.
- en=1, per channel, d = rise_dly if s=1 else fall_dly:
  - s == nn: cnt ← 0 (pending change cancelled — inertial rejection).
  - s != nn and cnt ≥ d: nn ← s, cnt ← 0.
  - s != nn and cnt < d: cnt ← cnt+1.
  - hist ← {hist[HIST_W-2:0], nn_next} every enabled edge; hence y bit 0 always equals nn.
- Comparison uses ≥ with live delay inputs: lowering a delay mid-count commits on the next enabled edge if cnt already ≥ new d. Raising it extends the wait.
- Counter cannot overflow: cnt ≤ d ≤ 2^CNT_W−1 by construction.
- Channels fully independent; simultaneous changes on several channels processed in parallel.

## Timing
- All outputs registered; no combinational path input→output.
- Input s held constantly different from nn: nn changes at the (d+1)-th consecutive enabled edge. d=0 → one-edge latency.
- A pulse of s lasting ≤ d enabled edges never reaches nn; busy is high for its duration then clears on the edge after s returns.
- busy rises at the first edge that increments cnt (never for d=0).
- y reflects nn's full history at one sample per enabled edge; oldest bit drops off the top.
- Reset mid-count: pending change discarded, outputs at reset values the edge after rst_n sampled low.

## Test plan
Configuration CH=2, HIST_W=8, CNT_W=4, INVERT=1.
- Reset: rst_n=0 for 2 edges with x=2'b11 → nn=2'b11, y=16'hFFFF, busy=2'b00; still so on the first edge after release when x=2'b00.
- Fall delay: fall_dly=1, en=1, x[0] 0→1 held → edge1 busy[0]=1, nn[0]=1, y[7:0]=8'hFF; edge2 nn[0]=0, y[7:0]=8'hFE, busy[0]=0; edge3 y[7:0]=8'hFC; channel 1 unchanged (y[15:8]=8'hFF).
- Inertial rejection: with nn[0]=0, rise_dly=3, x[0]=0 for exactly 3 edges then 1 → nn[0] stays 0, busy[0] high 3 cycles then 0; x[0]=0 held 4 edges → nn[0]=1 on edge 4.
- Zero delay: rise_dly=fall_dly=0, toggle x[1] every cycle → nn[1] = ~x[1] one edge later, busy[1] never asserted, y[15:8] alternates 8'h55/8'hAA.
- Enable freeze and live delay change: rise_dly=10, count to cnt=5, en=0 for 5 cycles → nn, y, busy constant; set rise_dly=2, en=1 → nn commits on the first enabled edge.
- Reset mid-count: cnt=3 pending on both channels, rst_n=0 for one edge → nn=2'b11, y=16'hFFFF, busy=0; pending changes lost.
